// File: rtl/telemetry_frame_scheduler.sv
// telemetry_frame_scheduler: latches NUM_CH 16-bit telemetry samples and serialises them round-robin as framed bytes to one UART.
// Define TELEM_CHECKSUM_EN to append an XOR checksum as a fifth frame byte.
module telemetry_frame_scheduler #(
   parameter int         NUM_CH    = 4,
   parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_CH-1:0]    i_ch_valid,
   input  logic [16*NUM_CH-1:0] i_ch_data,
   output logic [7:0]           o_tx_data,
   output logic                 o_tx_send,
   input  logic                 i_tx_ready,
   output logic                 o_busy,
   output logic                 o_frame_done,
   output logic [7:0]           o_overrun_cnt
);
`ifdef TELEM_CHECKSUM_EN
   localparam int IW = 3;
   localparam logic [IW-1:0] LAST = 3'd4;
`else
   localparam int IW = 2;
   localparam logic [IW-1:0] LAST = 2'd3;
`endif
   localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   typedef enum logic [1:0] {IDLE, SEND, SETTLE, WAIT} state_t;
   state_t            r_state, w_next;
   logic [15:0]       r_hold [NUM_CH];
   logic [NUM_CH-1:0] r_pend;
   logic [CW-1:0]     r_last, w_gnt, w_c;
   logic [2:0]        r_ch;
   logic [15:0]       r_buf;
   logic [IW-1:0]     r_idx;
   logic [7:0]        r_ovr, w_byte;
   logic              w_found, w_grant;
   logic [3:0]        w_ovr_n;
   logic [8:0]        w_ovr_sum;
   // Search starts just past the last grant so service rotates.
   always_comb begin
      w_found = 1'b0;
      w_gnt   = '0;
      w_c     = '0;
      for (int k = 1; k <= NUM_CH; k++) begin
         w_c = CW'((int'(r_last) + k) % NUM_CH);
         if (!w_found && r_pend[w_c]) begin
            w_found = 1'b1;
            w_gnt   = w_c;
         end
      end
   end
   assign w_grant = (r_state == IDLE) && w_found;
   always_comb begin
      w_ovr_n = '0;
      for (int i = 0; i < NUM_CH; i++)
         w_ovr_n = w_ovr_n + 4'(i_ch_valid[i] && r_pend[i] && !(w_grant && w_gnt == CW'(i)));
      w_ovr_sum = {1'b0, r_ovr} + 9'(w_ovr_n);
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_CH; i++) r_hold[i] <= '0;
         r_pend <= '0;
         r_last <= CW'(NUM_CH - 1);
         r_ch   <= '0;
         r_buf  <= '0;
         r_ovr  <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (i_ch_valid[i]) r_hold[i] <= i_ch_data[16*i +: 16];
            if (i_ch_valid[i]) r_pend[i] <= 1'b1;
            else if (w_grant && w_gnt == CW'(i)) r_pend[i] <= 1'b0;
         end
         r_ovr <= w_ovr_sum[8] ? 8'hFF : w_ovr_sum[7:0];
         if (w_grant) begin
            r_last <= w_gnt;
            r_ch   <= 3'(w_gnt);
            r_buf  <= r_hold[w_gnt];
         end
      end
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_idx   <= '0;
      end else begin
         r_state <= w_next;
         if (w_grant) r_idx <= '0;
         else if (r_state == WAIT && i_tx_ready && r_idx != LAST) r_idx <= r_idx + IW'(1);
      end
   end
   always_comb begin
      w_next       = r_state;
      o_frame_done = 1'b0;
      case (r_state)
         IDLE:    if (w_found) w_next = SEND;
         SEND:    if (i_tx_ready) w_next = SETTLE;
         SETTLE:  w_next = WAIT;
         WAIT:    if (i_tx_ready) begin
                     w_next       = (r_idx == LAST) ? IDLE : SEND;
                     o_frame_done = (r_idx == LAST);
                  end
         default: w_next = IDLE;
      endcase
   end
`ifdef TELEM_CHECKSUM_EN
   assign w_byte = (r_idx == IW'(1)) ? {5'b0, r_ch} :
                   (r_idx == IW'(2)) ? r_buf[15:8] :
                   (r_idx == IW'(3)) ? r_buf[7:0] :
                   (r_idx == IW'(4)) ? ({5'b0, r_ch} ^ r_buf[15:8] ^ r_buf[7:0]) : SYNC_BYTE;
`else
   assign w_byte = (r_idx == IW'(1)) ? {5'b0, r_ch} :
                   (r_idx == IW'(2)) ? r_buf[15:8] :
                   (r_idx == IW'(3)) ? r_buf[7:0] : SYNC_BYTE;
`endif
   assign o_tx_data     = (r_state == SEND) ? w_byte : 8'h00;
   assign o_tx_send     = (r_state == SEND) && i_tx_ready;
   assign o_busy        = (r_state != IDLE);
   assign o_overrun_cnt = r_ovr;
endmodule

// File: tb/tb_telemetry_frame_scheduler.sv
// tb_telemetry_frame_scheduler: directed bench for telemetry_frame_scheduler with a 10-cycle UART ready model.
// Frame length follows TELEM_CHECKSUM_EN (5 bytes when defined, else 4).
module tb_telemetry_frame_scheduler;
   localparam int NCH = 4;
`ifdef TELEM_CHECKSUM_EN
   localparam int FL = 5;
`else
   localparam int FL = 4;
`endif
   logic clk = 1'b0, reset = 1'b1, tx_ready = 1'b1;
   logic [NCH-1:0] ch_valid = '0;
   logic [16*NCH-1:0] ch_data = '0;
   logic [7:0] tx_data, overrun_cnt;
   logic tx_send, busy, frame_done;
   int tests = 0, fails = 0, cyc = 0, cnt = 0, done_cnt = 0, first_cyc = -1, bad_send = 0, c0 = 0;
   logic fall = 1'b0;
   logic [7:0] bytes [$];
   always #5 clk = ~clk;
   telemetry_frame_scheduler #(.NUM_CH(NCH), .SYNC_BYTE(8'hA5)) dut (
      .clk(clk), .reset(reset), .i_ch_valid(ch_valid), .i_ch_data(ch_data),
      .o_tx_data(tx_data), .o_tx_send(tx_send), .i_tx_ready(tx_ready),
      .o_busy(busy), .o_frame_done(frame_done), .o_overrun_cnt(overrun_cnt)
   );
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   // UART model: ready drops one cycle after an accepted send and returns 10 cycles later.
   task automatic step();
      @(negedge clk);
      cyc++;
      if (reset) begin tx_ready = 1'b1; cnt = 0; fall = 1'b0; end
      else if (fall) begin tx_ready = 1'b0; cnt = 10; fall = 1'b0; end
      else if (cnt > 0) begin cnt--; if (cnt == 0) tx_ready = 1'b1; end
      #1;
      if (tx_send) begin
         bytes.push_back(tx_data);
         fall = 1'b1;
         if (first_cyc < 0) first_cyc = cyc;
      end
      if (tx_send && !tx_ready) bad_send++;
      if (frame_done) done_cnt++;
   endtask
   task automatic pulse(input logic [NCH-1:0] m, input logic [16*NCH-1:0] d);
      ch_valid = m;
      ch_data  = d;
      step();
      ch_valid = '0;
   endtask
   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      bytes.delete();
      done_cnt = 0;
      first_cyc = -1;
      bad_send = 0;
   endtask
   task automatic wait_done(input string tag, input int n);
      for (int i = 0; i < 1000 && done_cnt < n; i++) step();
      check({tag, " frame_done reached"}, 32'(done_cnt >= n), 32'd1);
   endtask
   task automatic check_bytes(input string tag, input int off, input logic [39:0] exp);
      logic [31:0] o;
      for (int i = 0; i < FL; i++) begin
         o = (off + i < bytes.size()) ? {24'h0, bytes[off+i]} : 32'hFFFF_FFFF;
         check($sformatf("%s byte%0d", tag, i), o, {24'h0, exp[39-8*i -: 8]});
      end
   endtask
   initial begin
      step();
      check("reset tx_send", 32'(tx_send), 32'd0);
      check("reset tx_data", 32'(tx_data), 32'h00);
      check("reset busy", 32'(busy), 32'd0);
      check("reset frame_done", 32'(frame_done), 32'd0);
      check("reset overrun", 32'(overrun_cnt), 32'd0);
      reset = 1'b0;
      // Single frame on ch2, with latency to first send.
      pulse(4'b0100, {16'h0, 16'h1234, 32'h0});
      c0 = cyc;
      wait_done("t1", 1);
      check("t1 latency", 32'(first_cyc - c0), 32'd1);
      check("t1 length", 32'(bytes.size()), 32'(FL));
      check_bytes("t1", 0, 40'hA5_02_12_34_24);
      repeat (3) step();
      check("t1 single done", 32'(done_cnt), 32'd1);
      check("t1 idle busy", 32'(busy), 32'd0);
      // All four channels at once: strict rotation from ch0.
      do_reset();
      pulse(4'hF, {16'h3333, 16'h2222, 16'h1111, 16'h0000});
      wait_done("t2", 4);
      check("t2 length", 32'(bytes.size()), 32'(4 * FL));
      check_bytes("t2 ch0", 0, 40'hA5_00_00_00_00);
      check_bytes("t2 ch1", FL, 40'hA5_01_11_11_01);
      check_bytes("t2 ch2", 2 * FL, 40'hA5_02_22_22_02);
      check_bytes("t2 ch3", 3 * FL, 40'hA5_03_33_33_03);
      check("t2 overrun", 32'(overrun_cnt), 32'd0);
      // Three ch1 samples while ch0 transmits: two overruns, latest sample sent.
      do_reset();
      pulse(4'b0001, {48'h0, 16'h5A5A});
      step();
      pulse(4'b0010, {32'h0, 16'hAAAA, 16'h0});
      repeat (3) step();
      pulse(4'b0010, {32'h0, 16'hBBBB, 16'h0});
      step();
      pulse(4'b0010, {32'h0, 16'hCCCC, 16'h0});
      check("t3 overrun", 32'(overrun_cnt), 32'd2);
      wait_done("t3", 2);
      check_bytes("t3 ch0", 0, 40'hA5_00_5A_5A_00);
      check_bytes("t3 ch1", FL, 40'hA5_01_CC_CC_01);
      // UART not ready on entry to SEND.
      do_reset();
      tx_ready = 1'b0;
      cnt = 20;
      pulse(4'b0010, {32'h0, 16'h0F0F, 16'h0});
      repeat (12) step();
      check("t4 stalled no bytes", 32'(bytes.size()), 32'd0);
      check("t4 stalled busy", 32'(busy), 32'd1);
      wait_done("t4", 1);
      check("t4 send while not ready", 32'(bad_send), 32'd0);
      check("t4 length", 32'(bytes.size()), 32'(FL));
      check_bytes("t4", 0, 40'hA5_01_0F_0F_01);
      // Reset mid-frame drops the frame and pending samples.
      do_reset();
      pulse(4'b0100, {16'h0, 16'h7788, 32'h0});
      step();
      pulse(4'b0010, {32'h0, 16'h1111, 16'h0});
      pulse(4'b0010, {32'h0, 16'h2222, 16'h0});
      for (int i = 0; i < 300 && bytes.size() < 3; i++) step();
      check("t5 reached byte2", 32'(bytes.size()), 32'd3);
      check("t5 overrun before", 32'(overrun_cnt), 32'd1);
      reset = 1'b1;
      #1;
      check("t5 reset tx_send", 32'(tx_send), 32'd0);
      check("t5 reset tx_data", 32'(tx_data), 32'h00);
      check("t5 reset busy", 32'(busy), 32'd0);
      check("t5 reset frame_done", 32'(frame_done), 32'd0);
      check("t5 reset overrun", 32'(overrun_cnt), 32'd0);
      step();
      reset = 1'b0;
      bytes.delete();
      done_cnt = 0;
      pulse(4'b1000, {16'h9ABC, 48'h0});
      wait_done("t5", 1);
      repeat (20) step();
      check("t5 no stale frame", 32'(done_cnt), 32'd1);
      check("t5 length", 32'(bytes.size()), 32'(FL));
      check_bytes("t5 ch3", 0, 40'hA5_03_9A_BC_25);
      // ch0 0xBEEF; frame length follows the checksum build option.
      do_reset();
      pulse(4'b0001, {48'h0, 16'hBEEF});
      wait_done("t6", 1);
      check("t6 length", 32'(bytes.size()), 32'(FL));
      check_bytes("t6", 0, 40'hA5_00_BE_EF_51);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
